aes_inv_cipher_ctrl: RTL and testbench

Iterative AES-128 inverse-cipher controller: accepts one 128-bit ciphertext block over a valid/ready handshake and sequences the inverse round datapath (InvShiftRows, Inv_SubBytes, AddRoundKey, InvMixColumns) one round per clock over 10 rounds. It returns the plaintext over a second valid/ready handshake. It sits between the block-level I/O wrapper and an external round-key store, which it addresses by round index.

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/Inv_SubBytes.sv | 18 +
 rtl/aes_inv_mix_columns.sv | 28 ++
 rtl/aes_inv_cipher_ctrl.sv | 116 +++++++++++
 tb/tb_aes_inv_cipher_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, constants and GF(2^8) helpers.
//   NR_AES128       number of AES-128 rounds
//   aes_block_t     128-bit block, byte 0 in bits [127:120], column-major
//   aes_inv_state_e inverse-cipher controller FSM states
//   xtime / gf_mul / gf_inv / inv_sbox  byte arithmetic, reduction polynomial 0x11b
package aes_pkg;

  localparam int unsigned NR_AES128 = 10;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} aes_inv_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  // Inverse affine transform followed by multiplicative inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
    t = t ^ 8'h05;
    return gf_inv(t);
  endfunction

endpackage

// File: rtl/Inv_SubBytes.sv
// Inv_SubBytes: combinational inverse S-box applied to all 16 bytes of a block.
//   message   in  128  input block
//   Dmessage  out 128  byte-wise inverse-substituted block
module Inv_SubBytes
  import aes_pkg::*;
(
  input  logic [127:0] message,
  output logic [127:0] Dmessage
);

  always_comb begin
    Dmessage = '0;
    for (int i = 0; i < 16; i++) begin
      Dmessage[8*i +: 8] = inv_sbox(message[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_inv_mix_columns.sv
// aes_inv_mix_columns: combinational AES InvMixColumns over a full block.
//   data_i  in  128  state, column-major, byte 0 in bits [127:120]
//   data_o  out 128  each column multiplied by circulant {0e,0b,0d,09}
module aes_inv_mix_columns
  import aes_pkg::*;
(
  input  aes_block_t data_i,
  output aes_block_t data_o
);

  always_comb begin
    logic [31:0] col;
    data_o = '0;
    col    = '0;
    for (int c = 0; c < 4; c++) begin
      col = data_i[127-32*c -: 32];
      data_o[127-32*c -: 8] = gf_mul(8'h0e, col[31:24]) ^ gf_mul(8'h0b, col[23:16]) ^
                              gf_mul(8'h0d, col[15:8])  ^ gf_mul(8'h09, col[7:0]);
      data_o[119-32*c -: 8] = gf_mul(8'h09, col[31:24]) ^ gf_mul(8'h0e, col[23:16]) ^
                              gf_mul(8'h0b, col[15:8])  ^ gf_mul(8'h0d, col[7:0]);
      data_o[111-32*c -: 8] = gf_mul(8'h0d, col[31:24]) ^ gf_mul(8'h09, col[23:16]) ^
                              gf_mul(8'h0e, col[15:8])  ^ gf_mul(8'h0b, col[7:0]);
      data_o[103-32*c -: 8] = gf_mul(8'h0b, col[31:24]) ^ gf_mul(8'h0d, col[23:16]) ^
                              gf_mul(8'h09, col[15:8])  ^ gf_mul(8'h0e, col[7:0]);
    end
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES-128 inverse cipher, one round per clock.
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   ciphertext handshake (accepted only in idle)
//   rk_idx/round_key            round-key store address and same-cycle key data
//   out_valid/out_ready/out_data plaintext handshake (out_data is the state register)
//   busy                        high whenever not idle
//   abort                       only with AES_INV_ABORT_EN: drop the in-flight block
// Optional feature macro: AES_INV_ABORT_EN.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_INV_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [3:0] RkLast  = 4'(NR_AES128);
  localparam logic [3:0] RndInit = 4'(NR_AES128 - 1);

  aes_inv_state_e state_q, state_d;
  aes_block_t     st_q, st_d;
  logic [3:0]     rnd_q, rnd_d;

  aes_block_t isr, sb, ark, imc;

  // InvShiftRows: row r of column c takes the byte from column (c - r) mod 4.
  always_comb begin
    isr = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        isr[127-8*(4*c+r) -: 8] = st_q[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end

  Inv_SubBytes u_inv_sub_bytes (
    .message  (isr),
    .Dmessage (sb)
  );

  assign ark = sb ^ round_key;

  aes_inv_mix_columns u_inv_mix_columns (
    .data_i (ark),
    .data_o (imc)
  );

  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = RkLast;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d    = in_data ^ round_key;
          rnd_d   = RndInit;
          state_d = StRound;
        end
      end
      StRound: begin
        rk_idx = rnd_q;
        st_d   = imc;
        rnd_d  = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = StFinal;
      end
      StFinal: begin
        rk_idx  = 4'd0;
        st_d    = ark;
        state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
    endcase
`ifdef AES_INV_ABORT_EN
    // Abort wins over a concurrent out_ready in done.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      st_d    = '0;
      rnd_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      st_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
    end
  end

  assign out_data = st_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// tb_aes_inv_cipher_ctrl: directed bench for aes_inv_cipher_ctrl using FIPS-197 vectors.
// A behavioural key store (own key expansion) drives round_key from rk_idx; expected
// plaintexts are queued on acceptance and compared when out_valid is seen.
module tb_aes_inv_cipher_ctrl;

  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef AES_INV_ABORT_EN
  logic         abort;
`endif

  aes_inv_cipher_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef AES_INV_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Key store: two precomputed schedules, selected per block.
  logic [127:0] rk_a [0:10];
  logic [127:0] rk_b [0:10];
  bit           key_sel;
  assign round_key = (rk_idx > 4'd10) ? '0 : (key_sel ? rk_b[rk_idx] : rk_a[rk_idx]);

  int           n_tests = 0;
  int           n_fail  = 0;
  int           acc_cyc = 0;
  logic [127:0] exp_q [$];

  function automatic logic [7:0] t_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // Forward S-box by brute-force inverse search plus the forward affine map.
  function automatic logic [7:0] t_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    inv = '0;
    for (int y = 1; y < 256; y++) if (t_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++) begin
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
    end
    return s ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key, input bit sel);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {t_sbox(t[31:24]), t_sbox(t[23:16]), t_sbox(t[15:8]), t_sbox(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      if (sel) rk_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else     rk_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit ksel,
                      output int waits);
    key_sel  = ksel;
    in_data  = ct;
    in_valid = 1'b1;
    waits    = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    chkb("in_ready_at_accept", in_ready, 1'b1);
    chki("rk_idx_idle", int'(rk_idx), 10);
    acc_cyc = cyc + 1;
    exp_q.push_back(pt);
    @(negedge clk);
    // Not idle now: in_data must not be sampled.
    in_data = {$urandom, $urandom, $urandom, $urandom};
    chkb("busy_after_accept", busy, 1'b1);
  endtask

  // Waits (bounded) for out_valid, then checks latency and data against the scoreboard.
  task automatic recv(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chkb({tag, "_valid"}, out_valid, 1'b1);
    chki({tag, "_latency"}, cyc - acc_cyc, 10);
    chki({tag, "_rk_idx_done"}, int'(rk_idx), 10);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_scoreboard: observed output expected none queued", tag);
    end else begin
      chk({tag, "_data"}, out_data, exp_q.pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int out_prev;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    key_sel   = 1'b0;
`ifdef AES_INV_ABORT_EN
    abort     = 1'b0;
`endif
    expand(KeyC1, 1'b0);
    expand(KeyB, 1'b1);
    repeat (2) @(negedge clk);

    // Reset values
    chkb("rst_in_ready", in_ready, 1'b1);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, '0);
    chki("rst_rk_idx", int'(rk_idx), 10);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 with the round-key index walk 9..0 after acceptance
    out_ready = 1'b1;
    send(CtC1, PtC1, 1'b0, w);
    in_valid = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      chki("rk_seq", int'(rk_idx), k);
      chkb("no_early_valid", out_valid, 1'b0);
      @(negedge clk);
    end
    recv("c1");
    @(negedge clk);
    chkb("c1_back_idle", busy, 1'b0);

    // FIPS-197 B
    send(CtB, PtB, 1'b1, w);
    in_valid = 1'b0;
    recv("fips_b");
    @(negedge clk);

    // Backpressure: output held for 5 cycles while a second block waits
    out_ready = 1'b0;
    send(CtC1, PtC1, 1'b0, w);
    in_valid = 1'b0;
    recv("bp");
    in_valid = 1'b1;
    in_data  = CtB;
    key_sel  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chkb("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_data", out_data, PtC1);
      chkb("bp_in_ready_low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chkb("bp_release_valid", out_valid, 1'b0);
    chkb("bp_release_idle", busy, 1'b0);
    send(CtB, PtB, 1'b1, w);
    chki("bp_accept_wait", w, 0);
    in_valid = 1'b0;
    recv("bp_second");
    @(negedge clk);

    // Back-to-back: in_valid and out_ready held high; acceptance-to-acceptance is
    // 10 latency edges + 1 DONE->IDLE edge + 1 accept edge.
    send(CtC1, PtC1, 1'b0, w);
    recv("b2b0");
    out_prev = cyc;
    send(CtB, PtB, 1'b1, w);
    chki("b2b_wait1", w, 1);
    recv("b2b1");
    chki("b2b_spacing1", cyc - out_prev, 12);
    out_prev = cyc;
    send(CtC1, PtC1, 1'b0, w);
    chki("b2b_wait2", w, 1);
    in_valid = 1'b0;
    recv("b2b2");
    chki("b2b_spacing2", cyc - out_prev, 12);
    @(negedge clk);

    // Reset mid-round at rnd=5
    send(CtC1, PtC1, 1'b0, w);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chki("mid_rnd5", int'(rk_idx), 5);
    #1 rst_n = 1'b0;
    #1;
    chkb("mid_rst_in_ready", in_ready, 1'b1);
    chkb("mid_rst_out_valid", out_valid, 1'b0);
    chkb("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_out_data", out_data, '0);
    chki("mid_rst_rk_idx", int'(rk_idx), 10);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chkb("post_rst_no_valid", out_valid, 1'b0);
    end
    send(CtC1, PtC1, 1'b0, w);
    in_valid = 1'b0;
    recv("post_rst_c1");
    @(negedge clk);

`ifdef AES_INV_ABORT_EN
    // Abort at rnd=3
    send(CtC1, PtC1, 1'b0, w);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chki("abort_rnd3", int'(rk_idx), 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chkb("abort_idle", busy, 1'b0);
    chkb("abort_in_ready", in_ready, 1'b1);
    chk("abort_st_zero", out_data, '0);
    void'(exp_q.pop_back());
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chkb("abort_no_valid", out_valid, 1'b0);
    end
    // Abort together with out_ready in DONE
    out_ready = 1'b0;
    send(CtB, PtB, 1'b1, w);
    in_valid = 1'b0;
    recv("abort_done");
    abort     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chkb("abort_done_idle", busy, 1'b0);
    chkb("abort_done_valid", out_valid, 1'b0);
    chk("abort_done_st_zero", out_data, '0);
    @(negedge clk);
`endif

    chki("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
